uart_rx: RTL

Asynchronous serial receiver; the receive-side counterpart of the UART transmitter in the IB FPGA.
- Frame format: 8N1 (start 0, 8 data LSB first, stop 1). Extra idle/stop bits from the transmitter are tolerated.
- The line is oversampled with a single-cycle enable strobe from the shared baud divider.
- Each received byte is presented with a level data_valid / pulse data_ack handshake.
- An rts flow-control output tells the far-end transmitter when to hold off.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver state encoding.
// Kept separate so the transmitter can reuse the same definitions.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line.
// Resets to 1 so that an idle line does not look like a start bit.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, oversampled by a shared baud strobe, with a
// valid/ack output handshake and rts flow control.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      rx,
    input  logic                      os_en,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      data_valid,
    input  logic                      data_ack,
    output logic                      rts,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(UART_DATA_BITS);
    localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(UART_DATA_BITS - 1);

    logic                      rx_s;
    rx_state_e                 state_q, state_d;
    logic [TickW-1:0]          tick_q, tick_d;
    logic [BitW-1:0]           bitcnt_q, bitcnt_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      deliver;
    logic                      ack_now;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .nrst(nrst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
        if (os_en) begin
            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        tick_d  = '0;
                    end
                end
                StStart: begin
                    // Re-check at the start-bit centre to reject short glitches.
                    if (tick_q == TickHalf) begin
                        tick_d   = '0;
                        bitcnt_d = '0;
                        state_d  = rx_s ? StIdle : StData;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StData: begin
                    if (tick_q == TickLast) begin
                        shreg_d  = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
                        tick_d   = '0;
                        bitcnt_d = bitcnt_q + 1'b1;
                        if (bitcnt_q == BitLast) begin
                            state_d = StStop;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StStop: begin
                    // Leaving mid-stop-bit lets a back-to-back start bit be caught.
                    if (tick_q == TickLast) begin
                        tick_d = '0;
                        if (rx_s) begin
                            deliver = 1'b1;
                            state_d = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StBreak;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StBreak: begin
                    if (rx_s) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        ack_now   = data_ack & valid_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (deliver) begin
            if (!valid_q || ack_now) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (ack_now) begin
            valid_d = 1'b0;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign rts        = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
